count_wrap_monitor: RTL and testbench
=====================================

# count_wrap_monitor

Downstream consumer of the N-bit up/down counter's `count` output. Samples the raw count on a valid strobe, infers direction, and detects wrap-around: max→0 going up, 0→max going down. Maintains a signed epoch (wrap) counter to form an extended-width count, and flags illegal steps as faults. Also provides a hysteresis threshold flag for control logic further downstream.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `EPOCH_W`, 4: width of the signed epoch counter.
- `THR_HI`, 12: raw-count level at or above which `above` sets.
- `THR_LO`, 3: raw-count level at or below which `above` clears; must satisfy `THR_LO < THR_HI`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `count_in`, in, WIDTH: counter value.
- `count_vld`, in, 1: `count_in` is valid this cycle.
- `clr`, in, 1: synchronous clear of epoch, fault and tracking state.
- `ext_count`, out, EPOCH_W+WIDTH: concatenation `{epoch, last sample}`.
- `epoch`, out, EPOCH_W: two's-complement net wrap count.
- `dir`, out, 1: direction of last legal step; 1 = up, 0 = down.
- `wrap_up`, out, 1: one-cycle pulse on a max→0 step.
- `wrap_dn`, out, 1: one-cycle pulse on a 0→max step.
- `step_err`, out, 1: one-cycle pulse on an illegal step.
- `fault`, out, 1: sticky fault level.
- `above`, out, 1: hysteresis threshold flag.

## Operation
- FSM states: INIT, TRACK, FAULT. Reset and `clr` both go to INIT.
- INIT, first valid sample: store it as `prev`, go to TRACK. No events. `above` is evaluated.
- TRACK, each valid sample: compute `delta = count_in - prev` mod 2^WIDTH.
  - `delta == 1`: legal up step. `dir` = 1. If `prev` = all-ones, pulse `wrap_up` and increment `epoch`.
  - `delta == 2^WIDTH-1`: legal down step. `dir` = 0. If `prev` = 0, pulse `wrap_dn` and decrement `epoch`.
  - `delta == 0`: hold. No events; `dir` unchanged.
  - Any other value: pulse `step_err`, set `fault`, go to FAULT. `epoch` and `dir` unchanged.
  - `prev` is updated with every valid sample.
- FAULT:
  - `prev` keeps updating on valid samples.
  - `epoch` and `dir` are frozen; `wrap_up`, `wrap_dn` and `step_err` are suppressed.
  - Exit only via `clr` or reset.
- `epoch` wraps modulo 2^EPOCH_W with no saturation.
- `above`: set when `count_in >= THR_HI`; clear when `count_in <= THR_LO`; otherwise hold. Evaluated on valid samples in every state.
- `clr` together with `count_vld`: `clr` wins and the sample is discarded.
- `clr` effect: state INIT; `epoch`, `fault`, `dir` and `above` cleared; `prev` cleared.
- Reset mid-stream has the same effect as `clr`.

## Timing
- Every output is registered and updates on the edge that captures `count_vld`. Latency is 1 cycle.
- Event pulses last exactly one cycle and align with the updated `epoch` and `ext_count`.
- `count_vld` may be asserted on every cycle. No back-pressure.
- Reset values: `ext_count` 0, `epoch` 0, `dir` 0, `wrap_up` 0, `wrap_dn` 0, `step_err` 0, `fault` 0, `above` 0. FSM in INIT.
- With `count_vld` low, all levels hold and all pulses are 0.

## Structure
- Shared package holds:
  - FSM state encoding constants `ST_INIT`, `ST_TRACK`, `ST_FAULT`.
  - Step-class encoding `STEP_UP`, `STEP_DN`, `STEP_HOLD`, `STEP_BAD`.
- One natural sub-module: `step_classifier`. It is purely combinational: it takes `prev` and `count_in` and returns the step class plus wrap indications. The FSM, epoch register and hysteresis logic stay in the top module.

## Test plan
All scenarios use WIDTH=4, EPOCH_W=4, THR_HI=12, THR_LO=3.
1. Reset, then `count_vld` each cycle with 13,14,15,0,1 → one `wrap_up` pulse at the 0 sample; `epoch` = 1; `ext_count` = 0x11 after the 1 sample; `dir` = 1.
2. From `epoch` 0, feed 1,0,15,14 → `wrap_dn` at the 15 sample; `epoch` = 0xF (−1); `ext_count` = 0xFE; `dir` = 0.
3. Feed 5,5,6 with gaps in `count_vld` → no events; `dir` = 1 after the 6. Holds and gaps do not disturb state.
4. Feed 4,7 → `step_err` pulses once and `fault` goes high. A further 8,9,10,11,12,13,14,15,0 produces no `wrap_up` and `epoch` stays frozen. Then `clr` → `fault` 0, `epoch` 0, state INIT.
5. Ramp 0→15 then down to 0 → `above` rises at 12 and stays high on the way down until 3, where it clears.
6. `clr` and `count_vld` (value 9) in the same cycle → sample discarded; the next sample is treated as the first (INIT), with no events. Assert `rst_n` low mid-ramp → all outputs 0 on the next edge.

Source files
------------

// File: rtl/count_wrap_monitor_pkg.sv
// Shared encodings for the count wrap monitor: FSM states and step classes.
package count_wrap_monitor_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

endpackage

// File: rtl/count_wrap_monitor_step_classifier.sv
// Combinational classification of one counter step (prev -> count_in) with wrap detection.
module step_classifier
  import count_wrap_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_e            step,
  output logic             wrap_up,
  output logic             wrap_dn
);

  logic [WIDTH-1:0] delta;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    delta = count_in - prev;
    step  = STEP_BAD;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == WIDTH'(1)) begin
      step = STEP_UP;
    end else if (delta == '1) begin
      step = STEP_DN;
    end
    wrap_up = (step == STEP_UP) && (prev == '1);
    wrap_dn = (step == STEP_DN) && (prev == '0);
  end

endmodule

// File: rtl/count_wrap_monitor.sv
// Tracks an up/down counter's raw value, counts wraps into a signed epoch, flags illegal
// steps as a sticky fault and provides a hysteresis threshold flag.
module count_wrap_monitor
  import count_wrap_monitor_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int EPOCH_W = 4,
  parameter int THR_HI  = 12,
  parameter int THR_LO  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       count_vld,
  input  logic                       clr,
  output logic [EPOCH_W+WIDTH-1:0]   ext_count,
  output logic [EPOCH_W-1:0]         epoch,
  output logic                       dir,
  output logic                       wrap_up,
  output logic                       wrap_dn,
  output logic                       step_err,
  output logic                       fault,
  output logic                       above
);

  localparam logic [WIDTH-1:0] THR_HI_C = WIDTH'(THR_HI);
  localparam logic [WIDTH-1:0] THR_LO_C = WIDTH'(THR_LO);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               dir_q, dir_d;
  logic               fault_q, fault_d;
  logic               above_q, above_d;
  logic               wrap_up_q, wrap_up_d;
  logic               wrap_dn_q, wrap_dn_d;
  logic               step_err_q, step_err_d;

  step_e              step;
  logic               cls_wrap_up;
  logic               cls_wrap_dn;

  step_classifier #(.WIDTH(WIDTH)) u_step_classifier (
    .prev     (prev_q),
    .count_in (count_in),
    .step     (step),
    .wrap_up  (cls_wrap_up),
    .wrap_dn  (cls_wrap_dn)
  );

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    epoch_d    = epoch_q;
    dir_d      = dir_q;
    fault_d    = fault_q;
    above_d    = above_q;
    wrap_up_d  = 1'b0;
    wrap_dn_d  = 1'b0;
    step_err_d = 1'b0;

    // A clear takes priority over a coincident sample, which is dropped.
    if (clr) begin
      state_d = ST_INIT;
      prev_d  = '0;
      epoch_d = '0;
      dir_d   = 1'b0;
      fault_d = 1'b0;
      above_d = 1'b0;
    end else if (count_vld) begin
      prev_d = count_in;
      if (count_in >= THR_HI_C) begin
        above_d = 1'b1;
      end else if (count_in <= THR_LO_C) begin
        above_d = 1'b0;
      end

      unique case (state_q)
        ST_INIT: state_d = ST_TRACK;
        ST_TRACK: begin
          unique case (step)
            STEP_UP: begin
              dir_d     = 1'b1;
              wrap_up_d = cls_wrap_up;
              if (cls_wrap_up) epoch_d = epoch_q + EPOCH_W'(1);
            end
            STEP_DN: begin
              dir_d     = 1'b0;
              wrap_dn_d = cls_wrap_dn;
              if (cls_wrap_dn) epoch_d = epoch_q - EPOCH_W'(1);
            end
            STEP_HOLD: ;
            default: begin
              step_err_d = 1'b1;
              fault_d    = 1'b1;
              state_d    = ST_FAULT;
            end
          endcase
        end
        ST_FAULT: ;
        default: state_d = ST_INIT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      prev_q     <= '0;
      epoch_q    <= '0;
      dir_q      <= 1'b0;
      fault_q    <= 1'b0;
      above_q    <= 1'b0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      epoch_q    <= epoch_d;
      dir_q      <= dir_d;
      fault_q    <= fault_d;
      above_q    <= above_d;
      wrap_up_q  <= wrap_up_d;
      wrap_dn_q  <= wrap_dn_d;
      step_err_q <= step_err_d;
    end
  end

  assign ext_count = {epoch_q, prev_q};
  assign epoch     = epoch_q;
  assign dir       = dir_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_dn   = wrap_dn_q;
  assign step_err  = step_err_q;
  assign fault     = fault_q;
  assign above     = above_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed self-checking bench for count_wrap_monitor with hand-computed expectations.
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] count_in;
  logic       count_vld;
  logic       clr;
  logic [7:0] ext_count;
  logic [3:0] epoch;
  logic       dir, wrap_up, wrap_dn, step_err, fault, above;
  logic [5:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  count_wrap_monitor #(.WIDTH(4), .EPOCH_W(4), .THR_HI(12), .THR_LO(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .count_vld (count_vld),
    .clr       (clr),
    .ext_count (ext_count),
    .epoch     (epoch),
    .dir       (dir),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .step_err  (step_err),
    .fault     (fault),
    .above     (above)
  );

  always #5 clk = ~clk;

  // {wrap_up, wrap_dn, step_err, fault, dir, above}
  assign flags = {wrap_up, wrap_dn, step_err, fault, dir, above};

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic vld, input logic c, input logic [3:0] val);
    count_vld = vld;
    clr       = c;
    count_in  = val;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(1'b1, 1'b0, 4'd13);
    apply(1'b1, 1'b0, 4'd13);
    n_checks++;
    if (ext_count !== 8'h00) begin
      n_fail++; $display("FAIL reset_ext got %h exp 00", ext_count);
    end
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000000", flags);
    end
    n_checks++;
    if (epoch !== 4'h0) begin
      n_fail++; $display("FAIL reset_epoch got %h exp 0", epoch);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] v [5];
    logic [7:0] e_ext [5];
    logic [5:0] e_fl [5];
    v     = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
    e_ext = '{8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11};
    e_fl  = '{6'b000001, 6'b000011, 6'b000011, 6'b100010, 6'b000010};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, v[i]);
      n_checks++;
      if (ext_count !== e_ext[i]) begin
        n_fail++; $display("FAIL wrap_up_ext[%0d] got %h exp %h", i, ext_count, e_ext[i]);
      end
      n_checks++;
      if (flags !== e_fl[i]) begin
        n_fail++; $display("FAIL wrap_up_flags[%0d] got %b exp %b", i, flags, e_fl[i]);
      end
    end
    n_checks++;
    if (epoch !== 4'h1) begin
      n_fail++; $display("FAIL wrap_up_epoch got %h exp 1", epoch);
    end
  endtask

  task automatic test_wrap_dn();
    logic [3:0] v [4];
    logic [7:0] e_ext [4];
    logic [5:0] e_fl [4];
    apply(1'b0, 1'b1, 4'd0);
    n_checks++;
    if ({ext_count, flags} !== 14'h0) begin
      n_fail++; $display("FAIL wrap_dn_clr got %h/%b exp 00/000000", ext_count, flags);
    end
    v     = '{4'd1, 4'd0, 4'd15, 4'd14};
    e_ext = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    e_fl  = '{6'b000000, 6'b000000, 6'b010001, 6'b000001};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, v[i]);
      n_checks++;
      if (ext_count !== e_ext[i]) begin
        n_fail++; $display("FAIL wrap_dn_ext[%0d] got %h exp %h", i, ext_count, e_ext[i]);
      end
      n_checks++;
      if (flags !== e_fl[i]) begin
        n_fail++; $display("FAIL wrap_dn_flags[%0d] got %b exp %b", i, flags, e_fl[i]);
      end
    end
    n_checks++;
    if (epoch !== 4'hF) begin
      n_fail++; $display("FAIL wrap_dn_epoch got %h exp f", epoch);
    end
  endtask

  task automatic test_hold_gaps();
    logic       vl [6];
    logic [3:0] v [6];
    logic [7:0] e_ext [6];
    logic [5:0] e_fl [6];
    apply(1'b0, 1'b1, 4'd0);
    vl    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v     = '{4'd5, 4'd9, 4'd5, 4'd9, 4'd6, 4'd9};
    e_ext = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h06, 8'h06};
    e_fl  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000010};
    for (int i = 0; i < 6; i++) begin
      apply(vl[i], 1'b0, v[i]);
      n_checks++;
      if (ext_count !== e_ext[i]) begin
        n_fail++; $display("FAIL hold_ext[%0d] got %h exp %h", i, ext_count, e_ext[i]);
      end
      n_checks++;
      if (flags !== e_fl[i]) begin
        n_fail++; $display("FAIL hold_flags[%0d] got %b exp %b", i, flags, e_fl[i]);
      end
    end
  endtask

  task automatic test_fault();
    logic [3:0] v [17];
    logic [7:0] e_ext [17];
    logic [5:0] e_fl [17];
    apply(1'b0, 1'b1, 4'd0);
    v     = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9,
              4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd15};
    e_ext = '{8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h17, 8'h18, 8'h19,
              8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h10, 8'h1F};
    e_fl  = '{6'b000001, 6'b100010, 6'b000010, 6'b000010, 6'b000010, 6'b000010,
              6'b001110, 6'b000110, 6'b000110, 6'b000110, 6'b000110, 6'b000111,
              6'b000111, 6'b000111, 6'b000111, 6'b000110, 6'b000111};
    for (int i = 0; i < 17; i++) begin
      apply(1'b1, 1'b0, v[i]);
      n_checks++;
      if (ext_count !== e_ext[i]) begin
        n_fail++; $display("FAIL fault_ext[%0d] got %h exp %h", i, ext_count, e_ext[i]);
      end
      n_checks++;
      if (flags !== e_fl[i]) begin
        n_fail++; $display("FAIL fault_flags[%0d] got %b exp %b", i, flags, e_fl[i]);
      end
    end
    apply(1'b0, 1'b1, 4'd0);
    n_checks++;
    if ({ext_count, flags} !== 14'h0) begin
      n_fail++; $display("FAIL fault_clr got %h/%b exp 00/000000", ext_count, flags);
    end
    apply(1'b1, 1'b0, 4'd7);
    n_checks++;
    if ({ext_count, flags} !== {8'h07, 6'b000000}) begin
      n_fail++; $display("FAIL fault_reinit got %h/%b exp 07/000000", ext_count, flags);
    end
  endtask

  task automatic test_hysteresis();
    logic [5:0] exp_fl;
    apply(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b0, 4'(i));
      exp_fl = {4'b0000, (i != 0), (i >= 12)};
      n_checks++;
      if ({ext_count, flags} !== {4'h0, 4'(i), exp_fl}) begin
        n_fail++; $display("FAIL hyst_up[%0d] got %h/%b exp %h/%b", i, ext_count, flags, i, exp_fl);
      end
    end
    for (int i = 14; i >= 0; i--) begin
      apply(1'b1, 1'b0, 4'(i));
      exp_fl = {5'b00000, (i > 3)};
      n_checks++;
      if ({ext_count, flags} !== {4'h0, 4'(i), exp_fl}) begin
        n_fail++; $display("FAIL hyst_dn[%0d] got %h/%b exp %h/%b", i, ext_count, flags, i, exp_fl);
      end
    end
  endtask

  task automatic test_clr_and_reset();
    apply(1'b1, 1'b1, 4'd9);
    n_checks++;
    if ({ext_count, flags} !== 14'h0) begin
      n_fail++; $display("FAIL clr_vld got %h/%b exp 00/000000", ext_count, flags);
    end
    apply(1'b1, 1'b0, 4'd5);
    n_checks++;
    if ({ext_count, flags} !== {8'h05, 6'b000000}) begin
      n_fail++; $display("FAIL clr_first got %h/%b exp 05/000000", ext_count, flags);
    end
    apply(1'b0, 1'b1, 4'd0);
    apply(1'b1, 1'b0, 4'd14);
    apply(1'b1, 1'b0, 4'd15);
    apply(1'b1, 1'b0, 4'd0);
    n_checks++;
    if ({ext_count, flags} !== {8'h10, 6'b100010}) begin
      n_fail++; $display("FAIL pre_rst got %h/%b exp 10/100010", ext_count, flags);
    end
    rst_n = 1'b0;
    apply(1'b1, 1'b0, 4'd1);
    n_checks++;
    if ({ext_count, epoch, flags} !== 18'h0) begin
      n_fail++; $display("FAIL mid_rst got %h/%h/%b exp 00/0/000000", ext_count, epoch, flags);
    end
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 4'd13);
    n_checks++;
    if ({ext_count, flags} !== {8'h0D, 6'b000001}) begin
      n_fail++; $display("FAIL post_rst got %h/%b exp 0d/000001", ext_count, flags);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    count_in  = 4'd0;
    count_vld = 1'b0;
    clr       = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_dn();
    test_hold_gaps();
    test_fault();
    test_hysteresis();
    test_clr_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
